// File: rtl/fetch_queue_if.sv
// Handshake bundle between the PC unit / instruction memory, the fetch queue
// and the decode stage. The master side is the fetch/decode environment, the
// slave side is the queue itself.
interface fetch_queue_if #(
    parameter int AW = 2
);
    logic [31:0] InPC;
    logic [31:0] InInstr;
    logic        InValid;
    logic        Flush;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] OutPC;
    logic [31:0] OutInstr;
    logic [31:0] OutPC4;
    logic        Stall;
    logic [AW:0] Count;
    logic        AdrErr;

    modport master (
        output InPC, InInstr, InValid, Flush, OutReady,
        input  OutValid, OutPC, OutInstr, OutPC4, Stall, Count, AdrErr
    );

    modport slave (
        input  InPC, InInstr, InValid, Flush, OutReady,
        output OutValid, OutPC, OutInstr, OutPC4, Stall, Count, AdrErr
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of (PC, instruction)
// pairs between the fetch unit and decode. Full raises Stall, a redirect
// (Flush) empties the queue, and a misaligned fetch sets a sticky AdrErr.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, an aligned
// fetch arriving at an empty queue is presented to decode in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clk,
    input  logic          ReSet_n,
    fetch_queue_if.slave  bus
);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          adr_err_q, adr_err_d;

    logic          aligned_s;
    logic          full_s;
    logic          empty_s;
    logic          byp_s;
    logic          push_s;
    logic          pop_s;
    logic          out_valid_s;
    logic [31:0]   out_pc_s;
    logic [31:0]   out_instr_s;
    logic [31:0]   out_pc4_s;

    assign aligned_s = (bus.InPC[1:0] == 2'b00);
    // Stall and emptiness come only from the registered occupancy.
    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == {(AW+1){1'b0}});

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_s = empty_s & bus.InValid & aligned_s & ~bus.Flush;
`else
    assign byp_s = 1'b0;
`endif

    // A bypassed entry that decode takes immediately never enters storage.
    assign push_s = bus.InValid & ~full_s & ~bus.Flush & aligned_s
                  & ~(byp_s & bus.OutReady);
    assign pop_s  = ~empty_s & bus.OutReady & ~bus.Flush;

    // Head selection: stored entry, else bypassed input, else zeros.
    always_comb begin
        out_valid_s = 1'b0;
        out_pc_s    = 32'h0000_0000;
        out_instr_s = 32'h0000_0000;
        out_pc4_s   = 32'h0000_0000;
        if (!empty_s) begin
            out_valid_s = 1'b1;
            out_pc_s    = pc_mem_q[rd_ptr_q];
            out_instr_s = instr_mem_q[rd_ptr_q];
            out_pc4_s   = pc_mem_q[rd_ptr_q] + 32'd4;
        end else if (byp_s) begin
            out_valid_s = 1'b1;
            out_pc_s    = bus.InPC;
            out_instr_s = bus.InInstr;
            out_pc4_s   = bus.InPC + 32'd4;
        end else begin
            out_valid_s = 1'b0;
        end
    end

    // Next pointers, occupancy and sticky error; a redirect overrides traffic.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        adr_err_d = adr_err_q | (bus.InValid & ~aligned_s & ~bus.Flush);
        if (bus.Flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {(AW+1){1'b0}};
            adr_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            adr_err_q <= adr_err_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]    <= bus.InPC;
            instr_mem_q[wr_ptr_q] <= bus.InInstr;
        end
    end

    assign bus.OutValid = out_valid_s;
    assign bus.OutPC    = out_pc_s;
    assign bus.OutInstr = out_instr_s;
    assign bus.OutPC4   = out_pc4_s;
    assign bus.Stall    = full_s;
    assign bus.Count    = count_q;
    assign bus.AdrErr   = adr_err_q;
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC unit / instruction memory and the decode stage. Captures each fetched (PC, instruction) pair into a DEPTH-entry circular buffer, presents the oldest entry to decode with a valid/ready handshake, and drives `Stall` back to the PC unit when full. A branch/jump/jr redirect flushes all queued wrong-path instructions. It also supplies PC+4 for jal link writes.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, >= 2.
- `AW`, 2: pointer width = log2(DEPTH).

Ports:
- Clk, input, 1: clock, rising-edge.
- ReSet_n, input, 1: asynchronous active-low reset.
- InPC, input, 32: PC of the fetched instruction.
- InInstr, input, 32: fetched instruction word.
- InValid, input, 1: InPC/InInstr valid this cycle.
- Flush, input, 1: redirect (taken branch, j, jal, jr); discard contents.
- OutReady, input, 1: decode accepts the head entry this cycle.
- OutValid, output, 1: head entry valid.
- OutPC, output, 32: head PC; 0 when OutValid=0.
- OutInstr, output, 32: head instruction; 0 when OutValid=0.
- OutPC4, output, 32: OutPC+4 (mod 2^32); 0 when OutValid=0.
- Stall, output, 1: queue full; PC unit must hold PC.
- Count, output, AW+1: number of occupied entries, 0..DEPTH.
- AdrErr, output, 1: sticky misaligned-fetch flag.

## Operation
- State: storage array, wr_ptr, rd_ptr (AW bits, wrap DEPTH-1 -> 0), count (AW+1 bits), AdrErr.
- push = InValid & ~Stall & ~Flush & (InPC[1:0]==0).
- pop = OutValid & OutReady & ~Flush.
- push: store at wr_ptr, wr_ptr+1. pop: rd_ptr+1. count += push - pop; a simultaneous push and pop leaves count unchanged.
- Stall = (count==DEPTH), decoded from registered count only (no combinational path from InValid/OutReady).
- Full: InValid ignored and the entry is not written. The PC unit holds its PC, so it re-presents the same entry.
- Empty: OutValid=0 and OutReady has no effect.
- Flush: has priority over push and pop. On the next edge wr_ptr=rd_ptr=0, count=0. A same-cycle push or pop is discarded. AdrErr is not cleared.
- Misalignment: InValid with InPC[1:0]!=0 and not Flush sets AdrErr=1 (sticky until reset) and the entry is dropped. This holds even when Stall=1.
- OutPC/OutInstr are a combinational read of storage[rd_ptr], gated to 0 when empty.

## Timing
- Reset (asynchronous, ReSet_n=0): pointers 0, count 0, OutValid 0, OutPC/OutInstr/OutPC4 0, Stall 0, Count 0, AdrErr 0. Storage is not reset.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Latency without bypass: a push at edge N makes the entry appear at the head after edge N when the queue was empty (1 cycle).
- Stall rises after the edge that makes count=DEPTH and falls after the first pop edge.
- Throughput: one push and one pop per cycle.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - Applies when count==0, InValid=1, InPC aligned, Flush=0.
  - Outputs show InPC/InInstr/InPC+4 combinationally with OutValid=1 in the same cycle (0 latency).
  - If OutReady=1, the entry is consumed and not written; count stays 0.
  - If OutReady=0, it is written normally.
- Undefined: no bypass; OutValid depends only on registered count; minimum latency 1 cycle.

## Test plan
- Reset, then push PC 0x3000/0x3004/0x3008/0x300C with OutReady=0 -> Count=4, Stall=1 after 4th edge; 5th InValid (0x3010) not stored.
- Next, OutReady=1 for 4 cycles -> OutPC 0x3000, 0x3004, 0x3008, 0x300C in order, OutPC4 0x3004..0x3010; Stall drops after first pop; Count returns to 0, OutValid=0, outputs 0.
- Push and pop every cycle for 10 cycles from count=2 -> Count stays 2; pointers wrap with no loss or reordering.
- Count=3, assert Flush with InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, flushed-cycle input not stored; following push of 0x3040 appears at head.
- InValid with InPC=0x3002 -> AdrErr=1, Count unchanged; AdrErr stays 1 through a Flush and clears only on ReSet_n=0.
- With `FETCH_QUEUE_BYPASS_EN`, empty queue, InValid=1, InPC=0x3000, OutReady=1 -> OutValid=1 and OutPC=0x3000 same cycle, Count stays 0. Without the macro -> OutValid=1 one cycle later.
